// File: rtl/multicycle_control.sv
// Multicycle processor control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, plus a retired-instruction counter.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        take_branch,
    input  logic        mem_ready,
    output logic [1:0]  ALUop,
    output logic        alu_src_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StExecR  = 4'd2;
    localparam logic [3:0] StExecI  = 4'd3;
    localparam logic [3:0] StAddr   = 4'd4;
    localparam logic [3:0] StMemRd  = 4'd5;
    localparam logic [3:0] StMemWr  = 4'd6;
    localparam logic [3:0] StWbAlu  = 4'd7;
    localparam logic [3:0] StWbMem  = 4'd8;
    localparam logic [3:0] StBranch = 4'd9;
    localparam logic [3:0] StTrap   = 4'd10;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [3:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        retire     = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Captured here so ADDR does not depend on opcode afterwards.
                is_store_d = (opcode == OpStore);
                case (opcode)
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpLoad, OpStore: state_d = StAddr;
                    OpBranch:        state_d = StBranch;
                    default:         state_d = StTrap;
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StAddr:           state_d = is_store_q ? StMemWr : StMemRd;
            StMemRd: begin
                if (mem_ready) state_d = StWbMem;
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StWbAlu, StWbMem, StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            instret_q  <= instret_d;
        end
    end

    // Outputs decode from state only, except the FETCH/BRANCH handshake qualifiers.
    always_comb begin
        ALUop      = 2'b00;
        alu_src_b  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_branch  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StExecR: ALUop = 2'b10;
                StExecI: begin
                    ALUop     = 2'b11;
                    alu_src_b = 1'b1;
                end
                StAddr:  alu_src_b = 1'b1;
                StMemRd: mem_read  = 1'b1;
                StMemWr: mem_write = 1'b1;
                StWbAlu: reg_write = 1'b1;
                StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StBranch: begin
                    ALUop     = 2'b01;
                    pc_branch = take_branch;
                end
                StTrap:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: per-cycle expected state, strobes
// and instret are queued at drive time and compared at the falling edge.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        take_branch;
    logic        mem_ready;
    logic [1:0]  ALUop;
    logic        alu_src_b, mem_read, mem_write, ir_write, pc_write;
    logic        pc_branch, reg_write, mem_to_reg, illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    localparam logic [6:0] OpR = 7'b0110011;
    localparam logic [6:0] OpI = 7'b0010011;
    localparam logic [6:0] OpL = 7'b0000011;
    localparam logic [6:0] OpS = 7'b0100011;
    localparam logic [6:0] OpB = 7'b1100011;
    localparam logic [6:0] OpX = 7'b1111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [10:0] outs;
        logic [31:0] ir;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [31:0] ir_exp;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .take_branch(take_branch),
        .mem_ready  (mem_ready),
        .ALUop      (ALUop),
        .alu_src_b  (alu_src_b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_branch  (pc_branch),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // Output table: {ALUop[1:0], alu_src_b, mem_read, mem_write, ir_write, pc_write,
    // pc_branch, reg_write, mem_to_reg, illegal}
    function automatic logic [10:0] outs_for(input logic rst, input logic [3:0] st,
                                             input logic mr, input logic tk);
        logic [10:0] v;
        v = '0;
        if (!rst) begin
            case (st)
                4'd0:  v = {2'b00, 1'b0, 1'b1, 1'b0, mr, mr, 4'b0000};
                4'd2:  v = {2'b10, 9'b0};
                4'd3:  v = {2'b11, 1'b1, 8'b0};
                4'd4:  v = {2'b00, 1'b1, 8'b0};
                4'd5:  v = 11'b00_0_1000_0000;
                4'd6:  v = 11'b00_0_0100_0000;
                4'd7:  v = 11'b00_0_0000_0100;
                4'd8:  v = 11'b00_0_0000_0110;
                4'd9:  v = {2'b01, 1'b0, 4'b0000, tk, 3'b000};
                4'd10: v = 11'b00_0_0000_0001;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic cyc(input logic rst, input logic mr, input logic tk, input logic [6:0] op,
                       input logic [3:0] est, input logic [31:0] eir);
        exp_t e;
        exp_t got;
        logic [10:0] obs;
        @(posedge clk);
        #1;
        reset       = rst;
        mem_ready   = mr;
        take_branch = tk;
        opcode      = op;
        sb.push_back('{st: est, outs: outs_for(rst, est, mr, tk), ir: eir});
        @(negedge clk);
        e   = sb.pop_front();
        obs = {ALUop, alu_src_b, mem_read, mem_write, ir_write, pc_write,
               pc_branch, reg_write, mem_to_reg, illegal};
        got = '{st: state, outs: obs, ir: instret};
        checks++;
        assert (got.st === e.st) else begin
            errors++;
            $error("FAIL state: observed %0d expected %0d", got.st, e.st);
        end
        checks++;
        assert (got.outs === e.outs) else begin
            errors++;
            $error("FAIL outputs(st=%0d): observed %b expected %b", e.st, got.outs, e.outs);
        end
        checks++;
        assert (got.ir === e.ir) else begin
            errors++;
            $error("FAIL instret: observed %0h expected %0h", got.ir, e.ir);
        end
        checks++;
        assert (((mem_read & mem_write) | (pc_write & pc_branch)) === 1'b0) else begin
            errors++;
            $error("FAIL exclusive_strobes: observed %b%b%b%b expected no overlap",
                   mem_read, mem_write, pc_write, pc_branch);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; take_branch = 1'b0; opcode = 7'd0;
        ir_exp = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);

        // R-type, zero wait states: 0,1,2,7,0
        cyc(0, 1, 0, OpR, 0, ir_exp);
        cyc(0, 1, 0, OpR, 1, ir_exp);
        cyc(0, 1, 0, OpR, 2, ir_exp);
        cyc(0, 1, 0, OpR, 7, ir_exp);
        ir_exp++;

        // I-type with one fetch wait state
        cyc(0, 0, 0, OpI, 0, ir_exp);
        cyc(0, 1, 0, OpI, 0, ir_exp);
        cyc(0, 1, 0, OpI, 1, ir_exp);
        cyc(0, 1, 0, OpI, 3, ir_exp);
        cyc(0, 1, 0, OpI, 7, ir_exp);
        ir_exp++;

        // Load with three MEM_RD wait states: 8 cycles total
        cyc(0, 1, 0, OpL, 0, ir_exp);
        cyc(0, 1, 0, OpL, 1, ir_exp);
        cyc(0, 1, 0, OpL, 4, ir_exp);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, OpL, 5, ir_exp);
        cyc(0, 1, 0, OpL, 5, ir_exp);
        cyc(0, 1, 0, OpL, 8, ir_exp);
        ir_exp++;

        // Store, zero wait
        cyc(0, 1, 0, OpS, 0, ir_exp);
        cyc(0, 1, 0, OpS, 1, ir_exp);
        cyc(0, 1, 0, OpS, 4, ir_exp);
        cyc(0, 1, 0, OpS, 6, ir_exp);
        ir_exp++;

        // Branch taken, then not taken
        cyc(0, 1, 1, OpB, 0, ir_exp);
        cyc(0, 1, 1, OpB, 1, ir_exp);
        cyc(0, 1, 1, OpB, 9, ir_exp);
        ir_exp++;
        cyc(0, 1, 0, OpB, 0, ir_exp);
        cyc(0, 1, 0, OpB, 1, ir_exp);
        cyc(0, 1, 0, OpB, 9, ir_exp);
        ir_exp++;
        cyc(0, 1, 0, OpR, 0, ir_exp);

        // Store, then reset during MEM_WR wait
        cyc(0, 1, 0, OpS, 1, ir_exp);
        cyc(0, 0, 0, OpS, 4, ir_exp);
        cyc(0, 0, 0, OpS, 6, ir_exp);
        cyc(1, 0, 0, OpS, 6, ir_exp);
        ir_exp = 0;
        cyc(0, 1, 0, OpL, 0, ir_exp);

        // Load after reset must take the load path (store flag cleared)
        cyc(0, 1, 0, OpL, 1, ir_exp);
        cyc(0, 1, 0, OpL, 4, ir_exp);
        cyc(0, 1, 0, OpL, 5, ir_exp);
        cyc(0, 1, 0, OpL, 8, ir_exp);
        ir_exp++;

        // Illegal opcode: TRAP holds for 20 cycles, reset recovers
        cyc(0, 1, 0, OpX, 0, ir_exp);
        cyc(0, 1, 0, OpX, 1, ir_exp);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, OpX, 10, ir_exp);
        cyc(1, 1, 0, OpX, 10, ir_exp);
        ir_exp = 0;
        cyc(0, 1, 0, OpR, 0, ir_exp);

        // Counter wrap: preload all-ones while in WB_ALU, next retirement gives 0
        cyc(0, 1, 0, OpR, 1, ir_exp);
        cyc(0, 1, 0, OpR, 2, ir_exp);
        cyc(0, 1, 0, OpR, 7, ir_exp);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        ir_exp = 32'd0;
        cyc(0, 1, 0, OpR, 0, ir_exp);
        cyc(0, 1, 0, OpR, 1, ir_exp);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous and active-high.
REQ-003 SHALL have port opcode, input, 7 bits: instruction opcode field from the IR, stable from DECODE until the instruction retires.
REQ-004 SHALL have port take_branch, input, 1 bit: external branch-condition result, valid in BRANCH.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory handshake; access completes in any cycle where the request strobe and mem_ready are both high.
REQ-006 SHALL have port ALUop, output, 2 bits: ALUcontrol class (00 load/store add, 01 branch compare, 10 R-type, 11 I-type).
REQ-007 SHALL have the following single-bit outputs: alu_src_b (1 = immediate), mem_read, mem_write, ir_write, pc_write (PC+4), pc_branch (PC = target), reg_write, mem_to_reg, illegal.
REQ-008 SHALL have port state, output, 4 bits: current state encoding.
REQ-009 SHALL have port instret, output, 32 bits: retired-instruction count.

Function
REQ-010 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=10.
REQ-011 SHALL drive in FETCH: mem_read=1 and ALUop=00. ir_write and pc_write SHALL equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-012 SHALL spend exactly one cycle in DECODE and branch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other opcode -> TRAP
REQ-013 SHALL latch a load/store flag in DECODE; that flag alone SHALL select the ADDR successor.
REQ-014 SHALL drive in EXEC_R: ALUop=10, alu_src_b=0, then go to WB_ALU. In EXEC_I: ALUop=11, alu_src_b=1, then go to WB_ALU.
REQ-015 SHALL drive in ADDR: ALUop=00, alu_src_b=1, then go to MEM_RD (load) or MEM_WR (store).
REQ-016 SHALL hold mem_read=1 in MEM_RD until mem_ready, then go to WB_MEM. SHALL hold mem_write=1 in MEM_WR until mem_ready, then go to FETCH.
REQ-017 SHALL drive in WB_ALU: reg_write=1, mem_to_reg=0. In WB_MEM: reg_write=1, mem_to_reg=1. Both SHALL last exactly one cycle, then go to FETCH.
REQ-018 SHALL drive in BRANCH: ALUop=01, alu_src_b=0, pc_branch=take_branch, then go to FETCH.
REQ-019 SHALL drive illegal=1 in TRAP with all strobes 0, and remain in TRAP until reset.
REQ-020 SHALL hold every output not listed for the current state at 0, including ALUop=00.
REQ-021 SHALL never assert mem_read and mem_write together, and never assert pc_write and pc_branch together.
REQ-022 SHALL increment instret by 1 on each retirement edge: leaving WB_ALU, WB_MEM or BRANCH, or leaving MEM_WR with mem_ready=1.
REQ-023 SHALL wrap instret from 0xFFFFFFFF to 0 with no flag.
REQ-024 SHALL not count TRAP entry as a retirement.
REQ-025 SHALL give these cycle counts with zero wait states:
  - R-type and I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  Each wait cycle with mem_ready=0 SHALL add exactly one cycle.

Reset
REQ-026 SHALL, on a clock edge with reset=1, set state=FETCH and instret=0 and clear the latched load/store flag, regardless of the current state, including mid-wait in MEM_RD or MEM_WR.
REQ-027 SHALL force all strobes (mem_read, mem_write, ir_write, pc_write, pc_branch, reg_write) and illegal to 0 while reset=1.
REQ-028 SHALL assert mem_read=1 in the first cycle after reset deasserts.
REQ-029 SHALL let reset take priority over every transition, including TRAP.

Verification
REQ-030 SHALL cover: reset release, then opcode 0110011 with mem_ready=1 -> states 0,1,2,7,0; ALUop=10 in EXEC_R; reg_write for one cycle; instret=1.
REQ-031 SHALL cover: load 0000011 with mem_ready held 0 for 3 cycles in MEM_RD -> mem_read high for 4 MEM_RD cycles; WB_MEM has mem_to_reg=1; total 8 cycles.
REQ-032 SHALL cover: branch 1100011 twice, once with take_branch=1 and once with 0 -> pc_branch 1 then 0 in BRANCH; ALUop=01; instret increments 2.
REQ-033 SHALL cover: opcode 1111111 -> TRAP; illegal=1 for 20 cycles; instret unchanged; reset -> FETCH, illegal=0.
REQ-034 SHALL cover: reset asserted during MEM_WR wait -> next state FETCH; mem_write=0 during reset; instret=0.
REQ-035 SHALL cover: preload instret near 0xFFFFFFFF via 2^32-1 retirements (forced), one more retirement -> instret=0.
